// File: rtl/hog_svm_ctrl.sv
// hog_svm_ctrl: packs host coefficients into RAM lines + bias, then serves cell fetches and counts results per frame
module hog_svm_ctrl #(
  parameter int COEF_W = 20,
  parameter int N_COEF = 105,
  parameter int N_LINE = 36,
  parameter int ADDR_W = 6,
  parameter int IN_W   = 768,
  parameter int N_SW   = 1200,
  parameter int SW_W   = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic                     cfg_valid,
  input  logic [COEF_W-1:0]        cfg_data,
  output logic                     cfg_ready,
  output logic [ADDR_W-1:0]        addr_a,
  output logic                     write_en,
  output logic [N_COEF*COEF_W-1:0] i_data_a,
  output logic [COEF_W-1:0]        bias,
  output logic                     b_load,
  input  logic                     cell_valid,
  input  logic [IN_W-1:0]          cell_data,
  output logic                     cell_ready,
  input  logic                     request,
  output logic                     ready,
  output logic [IN_W-1:0]          i_data_fetch,
  input  logic                     o_valid,
  input  logic [SW_W-1:0]          sw_id,
  output logic                     busy,
  output logic                     cfg_done,
  output logic                     frame_done
);
  localparam int WORD_W = $clog2(N_COEF);
  localparam logic [WORD_W-1:0] LAST_W = WORD_W'(N_COEF - 1);
  localparam logic [ADDR_W-1:0] LAST_L = ADDR_W'(N_LINE - 1);
  localparam logic [SW_W-1:0] LAST_SW = SW_W'(N_SW - 1);
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, BIAS, RUN} state_t;
  state_t state;
  logic [WORD_W-1:0] word;
  logic [ADDR_W-1:0] line;
  logic [SW_W-1:0] sw_cnt;
  logic [N_COEF*COEF_W-1:0] line_buf, buf_nxt;
  logic acc, unused_sw;
  assign acc = cfg_valid && cfg_ready;
  assign unused_sw = ^sw_id;
  // The line is presented to the RAM with the final word already merged in
  always_comb begin
    buf_nxt = line_buf;
    buf_nxt[int'(word)*COEF_W +: COEF_W] = cfg_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      word         <= '0;
      line         <= '0;
      sw_cnt       <= '0;
      line_buf     <= '0;
      cfg_ready    <= 1'b0;
      addr_a       <= '0;
      write_en     <= 1'b0;
      i_data_a     <= '0;
      bias         <= '0;
      b_load       <= 1'b0;
      cell_ready   <= 1'b0;
      ready        <= 1'b0;
      i_data_fetch <= '0;
      busy         <= 1'b0;
      cfg_done     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      write_en   <= 1'b0;
      b_load     <= 1'b0;
      ready      <= 1'b0;
      cell_ready <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (cfg_start) begin
          state     <= LOAD;
          busy      <= 1'b1;
          cfg_ready <= 1'b1;
        end
        LOAD: if (acc) begin
          line_buf <= buf_nxt;
          word     <= (word == LAST_W) ? '0 : word + 1'b1;
          if (word == LAST_W) begin
            state     <= WRITE;
            cfg_ready <= 1'b0;
            write_en  <= 1'b1;
            addr_a    <= line;
            i_data_a  <= buf_nxt;
          end
        end
        WRITE: begin
          cfg_ready <= 1'b1;
          line      <= (line == LAST_L) ? '0 : line + 1'b1;
          state     <= (line == LAST_L) ? BIAS : LOAD;
        end
        BIAS: if (acc) begin
          bias      <= cfg_data;
          b_load    <= 1'b1;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
          cfg_done  <= 1'b1;
          state     <= RUN;
        end
        RUN: if (cfg_start) begin
          state     <= LOAD;
          busy      <= 1'b1;
          cfg_ready <= 1'b1;
          cfg_done  <= 1'b0;
          line      <= '0;
          word      <= '0;
          sw_cnt    <= '0;
        end else begin
          // !ready spaces issues two cycles apart so request can drop in between
          if (request && cell_valid && !ready) begin
            ready        <= 1'b1;
            cell_ready   <= 1'b1;
            i_data_fetch <= cell_data;
          end
          if (o_valid) begin
            sw_cnt     <= (sw_cnt == LAST_SW) ? '0 : sw_cnt + 1'b1;
            frame_done <= (sw_cnt == LAST_SW);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
